// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RDATA,
    RESP
  } lsu_state_t;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Size/sign legality plus natural alignment of a single access
  function automatic logic ls_legal(
    input logic       wr,
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic ok;
    ok = 1'b0;
    unique case (f3)
      LS_B, LS_BU: ok = 1'b1;
      LS_H, LS_HU: ok = ~off[0];
      LS_W:        ok = (off == 2'b00);
      default:     ok = 1'b0;
    endcase
    if (wr && f3[2]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Byte-lane steering: store replication/strobes and load shift/extend.
module lsu_data_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_off_i,
  input  logic [2:0]  st_func3_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_strb_o,
  input  logic [1:0]  ld_off_i,
  input  logic [2:0]  ld_func3_i,
  input  logic [31:0] ld_data_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shift;

  always_comb begin
    st_data_o = st_data_i;
    st_strb_o = 4'b1111;
    unique case (st_func3_i)
      LS_B, LS_BU: begin
        st_data_o = {4{st_data_i[7:0]}};
        st_strb_o = 4'b0001 << st_off_i;
      end
      LS_H, LS_HU: begin
        st_data_o = {2{st_data_i[15:0]}};
        st_strb_o = 4'b0011 << {st_off_i[1], 1'b0};
      end
      default: ;
    endcase
  end

  assign ld_shift = ld_data_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = ld_shift;
    unique case (ld_func3_i)
      LS_B:    ld_data_o = {{24{ld_shift[7]}}, ld_shift[7:0]};
      LS_H:    ld_data_o = {{16{ld_shift[15]}}, ld_shift[15:0]};
      LS_BU:   ld_data_o = {24'h0, ld_shift[7:0]};
      LS_HU:   ld_data_o = {16'h0, ld_shift[15:0]};
      default: ld_data_o = ld_shift;
    endcase
  end

endmodule

// File: rtl/lsu_axil_master.sv
// MEM-stage load/store unit: one RV32I load or store per request,
// issued as a single AXI4-Lite master transaction.
module lsu_axil_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_rd_en_i,
  input  logic              req_wr_en_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [2:0]        req_func3_i,
  output logic              lsu_busy_o,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              m_awvalid_o,
  input  logic              m_awready_i,
  output logic [ADDR_W-1:0] m_awaddr_o,
  output logic [2:0]        m_awprot_o,
  output logic              m_wvalid_o,
  input  logic              m_wready_i,
  output logic [31:0]       m_wdata_o,
  output logic [3:0]        m_wstrb_o,
  input  logic              m_bvalid_i,
  output logic              m_bready_o,
  input  logic [1:0]        m_bresp_i,
  output logic              m_arvalid_o,
  input  logic              m_arready_i,
  output logic [ADDR_W-1:0] m_araddr_o,
  output logic [2:0]        m_arprot_o,
  input  logic              m_rvalid_i,
  output logic              m_rready_o,
  input  logic [31:0]       m_rdata_i,
  input  logic [1:0]        m_rresp_i
);

  if (DATA_W != 32) begin : g_bad_dw
    $error("lsu_axil_master: DATA_W must be 32");
  end

  lsu_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        func3_q, func3_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req;
  logic              legal;
  logic [31:0]       st_data;
  logic [3:0]        st_strb;
  logic [31:0]       ld_data;

  lsu_data_align u_align (
    .st_off_i   (req_addr_i[1:0]),
    .st_func3_i (req_func3_i),
    .st_data_i  (req_wdata_i),
    .st_data_o  (st_data),
    .st_strb_o  (st_strb),
    .ld_off_i   (addr_q[1:0]),
    .ld_func3_i (func3_q),
    .ld_data_i  (m_rdata_i),
    .ld_data_o  (ld_data)
  );

  assign req   = req_rd_en_i | req_wr_en_i;
  assign legal = !(req_rd_en_i && req_wr_en_i) &&
                 ls_legal(req_wr_en_i, req_func3_i, req_addr_i[1:0]);

  assign m_awvalid_o = (state_q == WRITE) && !aw_done_q;
  assign m_wvalid_o  = (state_q == WRITE) && !w_done_q;
  assign m_bready_o  = (state_q == WRESP);
  assign m_arvalid_o = (state_q == READ);
  assign m_rready_o  = (state_q == RDATA);
  assign m_awaddr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign m_araddr_o  = {addr_q[ADDR_W-1:2], 2'b00};
  assign m_awprot_o  = 3'b000;
  assign m_arprot_o  = 3'b000;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = wstrb_q;

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = rsp_valid_o ? rdata_q : 32'h0;
  assign rsp_err_o   = rsp_valid_o & err_q;

  // Combinational so the stage stalls in the very cycle of the request
  assign lsu_busy_o = ((state_q == IDLE) && req) ||
                      ((state_q != IDLE) && (state_q != RESP));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    func3_d   = func3_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          addr_d    = req_addr_i;
          func3_d   = req_func3_i;
          wdata_d   = st_data;
          wstrb_d   = st_strb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = 32'h0;
          err_d     = !legal;
          if (!legal)          state_d = RESP;
          else if (req_wr_en_i) state_d = WRITE;
          else                 state_d = READ;
        end
      end
      WRITE: begin
        aw_done_d = aw_done_q | (m_awvalid_o & m_awready_i);
        w_done_d  = w_done_q | (m_wvalid_o & m_wready_i);
        if (aw_done_d && w_done_d) state_d = WRESP;
      end
      WRESP: begin
        if (m_bvalid_i) begin
          err_d   = (m_bresp_i != AXI_RESP_OKAY);
          state_d = RESP;
        end
      end
      READ: begin
        if (m_arready_i) state_d = RDATA;
      end
      RDATA: begin
        if (m_rvalid_i) begin
          err_d   = (m_rresp_i != AXI_RESP_OKAY);
          rdata_d = err_d ? 32'h0 : ld_data;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      func3_q   <= 3'b000;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'h0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      func3_q   <= func3_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_axil_master.sv
// Bench for lsu_axil_master: directed cases, randomized transactions
// against a reference model, and reset during a read.
module tb_lsu_axil_master;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_rd_en_i, req_wr_en_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic [2:0]  req_func3_i;
  logic        lsu_busy_o, rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        m_awvalid_o, m_awready_i;
  logic [31:0] m_awaddr_o;
  logic [2:0]  m_awprot_o;
  logic        m_wvalid_o, m_wready_i;
  logic [31:0] m_wdata_o;
  logic [3:0]  m_wstrb_o;
  logic        m_bvalid_i, m_bready_o;
  logic [1:0]  m_bresp_i;
  logic        m_arvalid_o, m_arready_i;
  logic [31:0] m_araddr_o;
  logic [2:0]  m_arprot_o;
  logic        m_rvalid_i, m_rready_o;
  logic [31:0] m_rdata_i;
  logic [1:0]  m_rresp_i;

  int errors = 0;
  int checks = 0;

  int          o_cyc, o_pulses, o_aw_hs, o_w_hs, o_ar_hs, o_b_hs, o_r_hs;
  int          o_busy_bad, o_unstable, o_bfirst, o_rfirst, o_aw_last, o_w_last;
  logic        o_err, o_timeout;
  logic [31:0] o_rdata, o_awaddr, o_wdata, o_araddr;
  logic [3:0]  o_wstrb;

  int          e_cyc, e_bfirst, e_rfirst;
  logic        e_err, e_store, e_load;
  logic [31:0] e_rdata, e_wdata, e_addr;
  logic [3:0]  e_strb;

  lsu_axil_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_rd_en_i(req_rd_en_i), .req_wr_en_i(req_wr_en_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_func3_i(req_func3_i),
    .lsu_busy_o(lsu_busy_o), .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_awaddr_o(m_awaddr_o), .m_awprot_o(m_awprot_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o),
    .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .m_bresp_i(m_bresp_i),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
    .m_araddr_o(m_araddr_o), .m_arprot_o(m_arprot_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
    .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i)
  );

  always #5 clk_i = ~clk_i;

  // Expected outcome of one request, derived from the ISA/AXI rules
  task automatic model(input logic rd, wr, input logic [31:0] addr, wd,
                       input logic [2:0] f3, input int aw_d, w_d, ar_d, b_d, r_d,
                       input logic [1:0] bresp, input logic [31:0] rdat,
                       input logic [1:0] rresp);
    int off; int wmax; logic bad; logic [31:0] v;
    off  = int'(addr % 4);
    bad  = (rd && wr) || (rd && (f3 == 3 || f3 >= 6)) || (wr && f3 > 2)
        || (f3 % 4 == 1 && off % 2 == 1) || (f3 == 2 && off != 0);
    e_store = !bad && wr;
    e_load  = !bad && rd;
    e_addr  = addr & ~32'd3;
    wmax = (aw_d > w_d) ? aw_d : w_d;
    if (f3 % 4 == 0) begin
      e_strb = 4'(1 << off); e_wdata = (wd % 256) * 32'h0101_0101;
    end else if (f3 % 4 == 1) begin
      e_strb = 4'(3 << off); e_wdata = (wd % 65536) * 32'h0001_0001;
    end else begin
      e_strb = 4'hF; e_wdata = wd;
    end
    v = rdat >> (8 * off);
    case (f3)
      3'd0: v = (v % 256 >= 128) ? (v % 256) + 32'hFFFF_FF00 : v % 256;
      3'd4: v = v % 256;
      3'd1: v = (v % 65536 >= 32768) ? (v % 65536) + 32'hFFFF_0000 : v % 65536;
      3'd5: v = v % 65536;
      default: v = rdat;
    endcase
    e_err   = bad || (e_store && bresp != 2'b00) || (e_load && rresp != 2'b00);
    e_rdata = (e_load && rresp == 2'b00) ? v : 32'h0;
    e_cyc   = bad ? 1 : (e_store ? 3 + wmax + b_d : 3 + ar_d + r_d);
    e_bfirst = 2 + wmax;
    e_rfirst = 2 + ar_d;
  endtask

  // Drives one request (called right after a negedge) and plays the slave;
  // readies wait the given number of cycles after valid is first seen.
  task automatic run_txn(input logic rd, wr, input logic [31:0] addr, wd,
                         input logic [2:0] f3, input int aw_d, w_d, ar_d, b_d, r_d,
                         input logic [1:0] bresp, input logic [31:0] rdat,
                         input logic [1:0] rresp, input logic hold);
    int awc, wc, arc, bc, rc, last; bit seen;
    logic [31:0] aw0, ar0, w0; logic [3:0] s0;
    awc = 0; wc = 0; arc = 0; bc = 0; rc = 0; seen = 0; last = 60;
    aw0 = 0; ar0 = 0; w0 = 0; s0 = 0;
    o_cyc = -1; o_pulses = 0; o_aw_hs = 0; o_w_hs = 0; o_ar_hs = 0;
    o_b_hs = 0; o_r_hs = 0; o_busy_bad = 0; o_unstable = 0;
    o_bfirst = -1; o_rfirst = -1; o_aw_last = -1; o_w_last = -1;
    o_err = 0; o_timeout = 0; o_rdata = 0;
    o_awaddr = 0; o_wdata = 0; o_araddr = 0; o_wstrb = 0;
    req_rd_en_i = rd; req_wr_en_i = wr; req_addr_i = addr;
    req_wdata_i = wd; req_func3_i = f3;
    #1;
    if (lsu_busy_o !== 1'b1) o_busy_bad++;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk_i);
      if (k == 1 && !hold) begin req_rd_en_i = 0; req_wr_en_i = 0; end
      if (!seen && (lsu_busy_o !== !rsp_valid_o)) o_busy_bad++;
      if (m_awvalid_o) begin
        if (awc == 0) aw0 = m_awaddr_o;
        if (m_awaddr_o !== aw0) o_unstable++;
        m_awready_i = (awc >= aw_d);
        if (m_awready_i) begin o_aw_hs++; o_awaddr = m_awaddr_o; o_aw_last = k; end
        awc++;
      end else m_awready_i = 0;
      if (m_wvalid_o) begin
        if (wc == 0) begin w0 = m_wdata_o; s0 = m_wstrb_o; end
        if (m_wdata_o !== w0 || m_wstrb_o !== s0) o_unstable++;
        m_wready_i = (wc >= w_d);
        if (m_wready_i) begin
          o_w_hs++; o_wdata = m_wdata_o; o_wstrb = m_wstrb_o; o_w_last = k;
        end
        wc++;
      end else m_wready_i = 0;
      if (m_arvalid_o) begin
        if (arc == 0) ar0 = m_araddr_o;
        if (m_araddr_o !== ar0) o_unstable++;
        m_arready_i = (arc >= ar_d);
        if (m_arready_i) begin o_ar_hs++; o_araddr = m_araddr_o; end
        arc++;
      end else m_arready_i = 0;
      if (m_bready_o) begin
        if (bc == 0) o_bfirst = k;
        m_bvalid_i = (bc >= b_d); m_bresp_i = bresp;
        if (m_bvalid_i) o_b_hs++;
        bc++;
      end else begin m_bvalid_i = 0; m_bresp_i = 0; end
      if (m_rready_o) begin
        if (rc == 0) o_rfirst = k;
        m_rvalid_i = (rc >= r_d); m_rdata_i = rdat; m_rresp_i = rresp;
        if (m_rvalid_i) o_r_hs++;
        rc++;
      end else begin m_rvalid_i = 0; m_rdata_i = 0; m_rresp_i = 0; end
      if (rsp_valid_o) begin
        o_pulses++;
        if (!seen) begin
          seen = 1; o_cyc = k; o_rdata = rsp_rdata_o; o_err = rsp_err_o;
          last = k + 1; req_rd_en_i = 0; req_wr_en_i = 0;
        end
      end
    end
    if (!seen) o_timeout = 1;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({m_awvalid_o, m_wvalid_o, m_bready_o, m_arvalid_o, m_rready_o,
         rsp_valid_o, rsp_err_o, lsu_busy_o} !== 8'h00) begin
      errors++; $display("FAIL reset_ctl got %b want 0", {m_awvalid_o, m_wvalid_o,
        m_bready_o, m_arvalid_o, m_rready_o, rsp_valid_o, rsp_err_o, lsu_busy_o});
    end
    checks++;
    if ({m_awaddr_o, m_araddr_o} !== 64'h0) begin
      errors++; $display("FAIL reset_addr got %h %h want 0", m_awaddr_o, m_araddr_o);
    end
    checks++;
    if ({m_wdata_o, m_wstrb_o, rsp_rdata_o} !== 68'h0) begin
      errors++; $display("FAIL reset_data got %h %h %h want 0", m_wdata_o, m_wstrb_o, rsp_rdata_o);
    end
    checks++;
    if ({m_awprot_o, m_arprot_o} !== 6'h0) begin
      errors++; $display("FAIL reset_prot got %h %h want 0", m_awprot_o, m_arprot_o);
    end
  endtask

  task automatic test_directed;
    run_txn(0, 1, 32'h100, 32'hDEADBEEF, 3'b010, 0, 0, 0, 0, 0, 2'b00, 32'h0, 2'b00, 0);
    checks++; if (o_awaddr !== 32'h100) begin errors++; $display("FAIL sw_awaddr got %h want 100", o_awaddr); end
    checks++; if (o_wstrb !== 4'hF) begin errors++; $display("FAIL sw_wstrb got %h want f", o_wstrb); end
    checks++; if (o_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata got %h want deadbeef", o_wdata); end
    checks++; if (o_bfirst != 2) begin errors++; $display("FAIL sw_bready got %0d want 2", o_bfirst); end
    checks++; if (o_cyc != 3 || o_err !== 1'b0) begin errors++; $display("FAIL sw_rsp got %0d/%b want 3/0", o_cyc, o_err); end
    checks++; if (o_busy_bad != 0) begin errors++; $display("FAIL sw_busy got %0d want 0", o_busy_bad); end

    run_txn(0, 1, 32'h103, 32'h000000AB, 3'b000, 0, 0, 0, 0, 0, 2'b00, 32'h0, 2'b00, 0);
    checks++; if (o_awaddr !== 32'h100) begin errors++; $display("FAIL sb_awaddr got %h want 100", o_awaddr); end
    checks++; if (o_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb got %b want 1000", o_wstrb); end
    checks++; if (o_wdata !== 32'hABABABAB) begin errors++; $display("FAIL sb_wdata got %h want abababab", o_wdata); end

    run_txn(1, 0, 32'h202, 32'h0, 3'b001, 0, 0, 0, 0, 0, 2'b00, 32'h80011234, 2'b00, 0);
    checks++; if (o_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL lh_rdata got %h want ffff8001", o_rdata); end
    checks++; if (o_araddr !== 32'h200 || o_cyc != 3) begin errors++; $display("FAIL lh_ar got %h/%0d want 200/3", o_araddr, o_cyc); end
    run_txn(1, 0, 32'h202, 32'h0, 3'b101, 0, 0, 0, 0, 0, 2'b00, 32'h80011234, 2'b00, 0);
    checks++; if (o_rdata !== 32'h00008001) begin errors++; $display("FAIL lhu_rdata got %h want 00008001", o_rdata); end
    run_txn(1, 0, 32'h201, 32'h0, 3'b000, 0, 0, 0, 0, 0, 2'b00, 32'h80011234, 2'b00, 0);
    checks++; if (o_rdata !== 32'h00000012) begin errors++; $display("FAIL lb_rdata got %h want 00000012", o_rdata); end

    run_txn(1, 0, 32'h101, 32'h0, 3'b010, 0, 0, 0, 0, 0, 2'b00, 32'h0, 2'b00, 0);
    checks++; if (o_ar_hs != 0 || o_cyc != 1 || o_err !== 1'b1) begin
      errors++; $display("FAIL lw_misalign got ar=%0d cyc=%0d err=%b want 0/1/1", o_ar_hs, o_cyc, o_err); end
    run_txn(0, 1, 32'h001, 32'h1234, 3'b001, 0, 0, 0, 0, 0, 2'b00, 32'h0, 2'b00, 0);
    checks++; if (o_aw_hs + o_w_hs != 0 || o_cyc != 1 || o_err !== 1'b1) begin
      errors++; $display("FAIL sh_misalign got aw=%0d cyc=%0d err=%b want 0/1/1", o_aw_hs, o_cyc, o_err); end

    run_txn(0, 1, 32'h40, 32'h11223344, 3'b010, 3, 0, 0, 0, 0, 2'b00, 32'h0, 2'b00, 0);
    checks++; if (o_aw_last != 4 || o_w_last != 1) begin
      errors++; $display("FAIL aw_delay got aw=%0d w=%0d want 4/1", o_aw_last, o_w_last); end
    checks++; if (o_bfirst != 5 || o_pulses != 1 || o_cyc != 6) begin
      errors++; $display("FAIL aw_delay_rsp got b=%0d p=%0d c=%0d want 5/1/6", o_bfirst, o_pulses, o_cyc); end

    run_txn(1, 0, 32'h80, 32'h0, 3'b010, 0, 0, 0, 0, 0, 2'b00, 32'h55, 2'b10, 0);
    checks++; if (o_err !== 1'b1 || o_rdata !== 32'h0) begin
      errors++; $display("FAIL rd_slverr got %b/%h want 1/0", o_err, o_rdata); end
    run_txn(0, 1, 32'h84, 32'h77, 3'b010, 0, 0, 0, 1, 0, 2'b11, 32'h0, 2'b00, 0);
    checks++; if (o_err !== 1'b1 || o_cyc != 4) begin
      errors++; $display("FAIL wr_decerr got %b/%0d want 1/4", o_err, o_cyc); end
    run_txn(1, 1, 32'h88, 32'h77, 3'b010, 0, 0, 0, 0, 0, 2'b00, 32'h0, 2'b00, 0);
    checks++; if (o_aw_hs + o_ar_hs != 0 || o_cyc != 1 || o_err !== 1'b1) begin
      errors++; $display("FAIL both_en got hs=%0d cyc=%0d err=%b want 0/1/1", o_aw_hs + o_ar_hs, o_cyc, o_err); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = 32'h400 + 32'(4 * i);
      run_txn(1, 0, a, 32'h0, 3'b010, 0, 0, 0, 0, 0, 2'b00, a ^ 32'h5A5A0000, 2'b00, 1);
      checks++; if (o_rdata !== (a ^ 32'h5A5A0000) || o_pulses != 1 || o_ar_hs != 1) begin
        errors++; $display("FAIL b2b%0d got %h p=%0d ar=%0d want %h 1 1", i, o_rdata, o_pulses, o_ar_hs, a ^ 32'h5A5A0000); end
    end
  endtask

  task automatic test_random(input int n);
    logic rd, wr, hold; logic [31:0] addr, wd, rdat; logic [2:0] f3;
    logic [1:0] bresp, rresp; int k, aw_d, w_d, ar_d, b_d, r_d;
    for (int i = 0; i < n; i++) begin
      k  = int'($urandom_range(0, 19));
      rd = (k < 9) || (k >= 18);
      wr = (k >= 9);
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else if (wr) f3 = 3'($urandom_range(0, 2));
      else begin k = int'($urandom_range(0, 4)); f3 = 3'((k < 3) ? k : k + 1); end
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      wd = $urandom; rdat = $urandom;
      aw_d = int'($urandom_range(0, 3)); w_d = int'($urandom_range(0, 3));
      ar_d = int'($urandom_range(0, 3));
      b_d = int'($urandom_range(0, 2)); r_d = int'($urandom_range(0, 2));
      bresp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rresp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      hold = 1'($urandom_range(0, 1));
      model(rd, wr, addr, wd, f3, aw_d, w_d, ar_d, b_d, r_d, bresp, rdat, rresp);
      run_txn(rd, wr, addr, wd, f3, aw_d, w_d, ar_d, b_d, r_d, bresp, rdat, rresp, hold);
      checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL rnd%0d timeout got %b want 0", i, o_timeout); end
      checks++; if (o_cyc != e_cyc) begin errors++; $display("FAIL rnd%0d cyc got %0d want %0d", i, o_cyc, e_cyc); end
      checks++; if (o_pulses != 1) begin errors++; $display("FAIL rnd%0d pulses got %0d want 1", i, o_pulses); end
      checks++; if (o_err !== e_err) begin errors++; $display("FAIL rnd%0d err got %b want %b", i, o_err, e_err); end
      checks++; if (o_rdata !== e_rdata) begin errors++; $display("FAIL rnd%0d rdata got %h want %h", i, o_rdata, e_rdata); end
      checks++; if (o_busy_bad != 0 || o_unstable != 0) begin
        errors++; $display("FAIL rnd%0d busy/stable got %0d/%0d want 0/0", i, o_busy_bad, o_unstable); end
      checks++; if (o_aw_hs != int'(e_store) || o_w_hs != int'(e_store) || o_ar_hs != int'(e_load)) begin
        errors++; $display("FAIL rnd%0d hs got %0d/%0d/%0d want %0d/%0d/%0d", i,
          o_aw_hs, o_w_hs, o_ar_hs, e_store, e_store, e_load); end
      if (e_store) begin
        checks++; if (o_awaddr !== e_addr || o_wdata !== e_wdata || o_wstrb !== e_strb) begin
          errors++; $display("FAIL rnd%0d wr got %h/%h/%h want %h/%h/%h", i,
            o_awaddr, o_wdata, o_wstrb, e_addr, e_wdata, e_strb); end
        checks++; if (o_bfirst != e_bfirst) begin
          errors++; $display("FAIL rnd%0d bready got %0d want %0d", i, o_bfirst, e_bfirst); end
      end
      if (e_load) begin
        checks++; if (o_araddr !== e_addr || o_rfirst != e_rfirst) begin
          errors++; $display("FAIL rnd%0d rd got %h/%0d want %h/%0d", i, o_araddr, o_rfirst, e_addr, e_rfirst); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int spurious;
    req_rd_en_i = 1; req_wr_en_i = 0; req_addr_i = 32'h300;
    req_func3_i = 3'b010; req_wdata_i = 0;
    @(negedge clk_i);
    req_rd_en_i = 0;
    checks++; if (m_arvalid_o !== 1'b1) begin errors++; $display("FAIL rst_mid_ar got %b want 1", m_arvalid_o); end
    m_arready_i = 1;
    @(negedge clk_i);
    m_arready_i = 0;
    checks++; if (m_rready_o !== 1'b1 || lsu_busy_o !== 1'b1) begin
      errors++; $display("FAIL rst_mid_rdata got %b/%b want 1/1", m_rready_o, lsu_busy_o); end
    #2 rst_i = 1;
    #1;
    checks++; if ({m_rready_o, lsu_busy_o, m_arvalid_o, rsp_valid_o} !== 4'b0) begin
      errors++; $display("FAIL rst_mid_drop got %b want 0000", {m_rready_o, lsu_busy_o, m_arvalid_o, rsp_valid_o}); end
    @(negedge clk_i);
    rst_i = 0;
    spurious = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (rsp_valid_o || lsu_busy_o || m_rready_o) spurious++;
    end
    checks++; if (spurious != 0) begin errors++; $display("FAIL rst_mid_idle got %0d want 0", spurious); end
    run_txn(1, 0, 32'h304, 32'h0, 3'b010, 0, 0, 1, 0, 1, 2'b00, 32'hCAFEF00D, 2'b00, 0);
    checks++; if (o_rdata !== 32'hCAFEF00D || o_cyc != 5) begin
      errors++; $display("FAIL rst_mid_after got %h/%0d want cafef00d/5", o_rdata, o_cyc); end
  endtask

  initial begin
    req_rd_en_i = 0; req_wr_en_i = 0; req_addr_i = 0;
    req_wdata_i = 0; req_func3_i = 0;
    m_awready_i = 0; m_wready_i = 0; m_bvalid_i = 0; m_bresp_i = 0;
    m_arready_i = 0; m_rvalid_i = 0; m_rdata_i = 0; m_rresp_i = 0;
    test_reset;
    @(negedge clk_i);
    rst_i = 0;
    @(negedge clk_i);
    test_directed;
    test_back_to_back;
    test_random(80);
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
